// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execute sequencer: opcodes, field positions, FSM states.
// Opcode 9 (MUL) is legal only when EXEC_SEQ_MUL_EN is defined.
package exec_sequencer_pkg;

   localparam int unsigned DefaultDw = 32;
   localparam int unsigned DefaultAw = 2;

   localparam int unsigned OpLsb  = 28;
   localparam int unsigned OpW    = 4;
   localparam int unsigned RdLsb  = 26;
   localparam int unsigned Rs1Lsb = 24;
   localparam int unsigned Rs2Lsb = 22;
   localparam int unsigned ImmLsb = 0;
   localparam int unsigned ImmW   = 16;

   localparam logic [OpW-1:0] OpNop  = 4'h0;
   localparam logic [OpW-1:0] OpAdd  = 4'h1;
   localparam logic [OpW-1:0] OpSub  = 4'h2;
   localparam logic [OpW-1:0] OpAnd  = 4'h3;
   localparam logic [OpW-1:0] OpOr   = 4'h4;
   localparam logic [OpW-1:0] OpXor  = 4'h5;
   localparam logic [OpW-1:0] OpSlt  = 4'h6;
   localparam logic [OpW-1:0] OpAddi = 4'h7;
   localparam logic [OpW-1:0] OpLi   = 4'h8;
   localparam logic [OpW-1:0] OpMul  = 4'h9;

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StExec,
      StWb
   } state_e;

   function automatic logic op_legal(input logic [OpW-1:0] op);
`ifdef EXEC_SEQ_MUL_EN
      return op <= OpMul;
`else
      return op <= OpLi;
`endif
   endfunction

   // Ops whose write-back updates Ovf; every other writing op clears it.
   function automatic logic op_arith(input logic [OpW-1:0] op);
      return (op == OpAdd) || (op == OpSub) || (op == OpAddi);
   endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the execute sequencer; result is modulo 2^DW.
// The multiplier exists only when EXEC_SEQ_MUL_EN is defined.
module exec_alu
   import exec_sequencer_pkg::*;
#(
   parameter int unsigned DW = DefaultDw
) (
   input  logic [OpW-1:0]  op,
   input  logic [DW-1:0]   a,
   input  logic [DW-1:0]   b,
   input  logic [ImmW-1:0] imm,
   output logic [DW-1:0]   result,
   output logic            ovf
);

   logic [DW-1:0] imm_ext;
   logic [DW-1:0] sum;
   logic [DW-1:0] diff;
   logic [DW-1:0] sum_imm;

   assign imm_ext = {{(DW-ImmW){imm[ImmW-1]}}, imm};
   assign sum     = a + b;
   assign diff    = a - b;
   assign sum_imm = a + imm_ext;

`ifdef EXEC_SEQ_MUL_EN
   logic [DW-1:0] prod;
   // Low DW bits of a product are identical for signed and unsigned operands.
   assign prod = a * b;
`endif

   always_comb begin
      result = '0;
      ovf    = 1'b0;
      case (op)
         OpAdd: begin
            result = sum;
            ovf    = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
         end
         OpSub: begin
            result = diff;
            ovf    = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
         end
         OpAnd:  result = a & b;
         OpOr:   result = a | b;
         OpXor:  result = a ^ b;
         OpSlt:  result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
         OpAddi: begin
            result = sum_imm;
            ovf    = (a[DW-1] == imm_ext[DW-1]) && (sum_imm[DW-1] != a[DW-1]);
         end
         OpLi:   result = imm_ext;
`ifdef EXEC_SEQ_MUL_EN
         OpMul:  result = prod;
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/exec_sequencer.sv
// Execute/control stage mastering a 4x32 register file: read, execute, write-back.
// Build with EXEC_SEQ_MUL_EN defined to enable opcode 9 (MUL).
module exec_sequencer
   import exec_sequencer_pkg::*;
#(
   parameter int unsigned DW = DefaultDw,
   parameter int unsigned AW = DefaultAw
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          InstrValid,
   input  logic [31:0]   Instruction,
   output logic          InstrReady,
   output logic          RegWrite,
   output logic [AW-1:0] ReadReg1,
   output logic [AW-1:0] ReadReg2,
   output logic [AW-1:0] WriteReg,
   output logic [DW-1:0] WriteData,
   input  logic [DW-1:0] ReadData1,
   input  logic [DW-1:0] ReadData2,
   output logic          Done,
   output logic          Illegal,
   output logic          Zero,
   output logic          Ovf
);

   state_e        state_q;
   logic [31:0]   instr_q;
   logic [OpW-1:0] op;
   logic [AW-1:0] rd;
   logic [DW-1:0] alu_result;
   logic          alu_ovf;
   logic          unused_instr;

   assign op           = instr_q[OpLsb +: OpW];
   assign rd           = instr_q[RdLsb +: AW];
   // Source fields go straight to ReadReg1/2 at accept time.
   assign unused_instr = ^instr_q[25:16];

   // Combinational so the sequencer is ready while held in reset.
   assign InstrReady = (state_q == StIdle);

   exec_alu #(
      .DW (DW)
   ) u_alu (
      .op     (op),
      .a      (ReadData1),
      .b      (ReadData2),
      .imm    (instr_q[ImmLsb +: ImmW]),
      .result (alu_result),
      .ovf    (alu_ovf)
   );

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q   <= StIdle;
         instr_q   <= '0;
         RegWrite  <= 1'b0;
         ReadReg1  <= '0;
         ReadReg2  <= '0;
         WriteReg  <= '0;
         WriteData <= '0;
         Done      <= 1'b0;
         Illegal   <= 1'b0;
         Zero      <= 1'b0;
         Ovf       <= 1'b0;
      end else begin
         RegWrite <= 1'b0;
         Done     <= 1'b0;
         Illegal  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (InstrValid) begin
                  instr_q  <= Instruction;
                  ReadReg1 <= Instruction[Rs1Lsb +: AW];
                  ReadReg2 <= Instruction[Rs2Lsb +: AW];
                  state_q  <= StRead;
               end
            end
            StRead: begin
               state_q <= StExec;
            end
            StExec: begin
               if (op == OpNop) begin
                  Done    <= 1'b1;
                  state_q <= StIdle;
               end else if (!op_legal(op)) begin
                  Illegal <= 1'b1;
                  state_q <= StIdle;
               end else begin
                  RegWrite  <= 1'b1;
                  WriteReg  <= rd;
                  WriteData <= alu_result;
                  Done      <= 1'b1;
                  Zero      <= (alu_result == '0);
                  Ovf       <= op_arith(op) ? alu_ovf : 1'b0;
                  state_q   <= StWb;
               end
            end
            StWb: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a register-file model and an ISA-level scoreboard.
// Expectations for opcode 9 follow EXEC_SEQ_MUL_EN.
module tb_exec_sequencer;

   localparam longint MaxS = 64'sd2147483647;
   localparam longint MinS = -64'sd2147483648;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        InstrValid = 1'b0;
   logic [31:0] Instruction = '0;
   logic        InstrReady, RegWrite, Done, Illegal, Zero, Ovf;
   logic [1:0]  ReadReg1, ReadReg2, WriteReg;
   logic [31:0] WriteData;
   logic [31:0] ReadData1 = '0;
   logic [31:0] ReadData2 = '0;

   logic [31:0] rf [4] = '{32'h0, 32'h0, 32'h0, 32'h0};

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;

   // Architectural model state
   logic [31:0] arch [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
   bit          m_zero = 1'b0;
   bit          m_ovf = 1'b0;
   logic [1:0]  m_rr1 = '0;
   logic [1:0]  m_rr2 = '0;
   bit          pend_valid = 1'b0;
   int          pend_k = 0;
   int          pend_end = 0;
   bit          pend_wr, pend_ill, pend_ar, pend_ovf;
   logic [1:0]  pend_rd, pend_rs1, pend_rs2;
   logic [31:0] pend_res;

   always #5 Clk = ~Clk;

   exec_sequencer #(
      .DW (32),
      .AW (2)
   ) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .InstrValid  (InstrValid),
      .Instruction (Instruction),
      .InstrReady  (InstrReady),
      .RegWrite    (RegWrite),
      .ReadReg1    (ReadReg1),
      .ReadReg2    (ReadReg2),
      .WriteReg    (WriteReg),
      .WriteData   (WriteData),
      .ReadData1   (ReadData1),
      .ReadData2   (ReadData2),
      .Done        (Done),
      .Illegal     (Illegal),
      .Zero        (Zero),
      .Ovf         (Ovf)
   );

   // Register file: registered reads only on cycles without a write.
   always @(posedge Clk) begin
      if (RegWrite) begin
         rf[WriteReg] <= WriteData;
      end else begin
         ReadData1 <= rf[ReadReg1];
         ReadData2 <= rf[ReadReg2];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs2,
                                      input logic [15:0] imm);
      return {op, rd, rs1, rs2, 6'd0, imm};
   endfunction

   // ISA-level result of w against the architectural registers; accept at edge cyc+1.
   task automatic model_compute(input logic [31:0] w);
      logic [31:0] a, b;
      longint sa, sb, si, r;
      a  = arch[w[25:24]];
      b  = arch[w[23:22]];
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      si = longint'($signed(w[15:0]));
      r  = 0;
      pend_wr  = 1'b1;
      pend_ill = 1'b0;
      pend_ar  = 1'b0;
      case (w[31:28])
         4'd0: pend_wr = 1'b0;
         4'd1: begin r = sa + sb; pend_ar = 1'b1; end
         4'd2: begin r = sa - sb; pend_ar = 1'b1; end
         4'd3: r = longint'(a & b);
         4'd4: r = longint'(a | b);
         4'd5: r = longint'(a ^ b);
         4'd6: r = (sa < sb) ? 1 : 0;
         4'd7: begin r = sa + si; pend_ar = 1'b1; end
         4'd8: r = si;
`ifdef EXEC_SEQ_MUL_EN
         4'd9: r = sa * sb;
`endif
         default: begin pend_wr = 1'b0; pend_ill = 1'b1; end
      endcase
      pend_res   = r[31:0];
      pend_ovf   = pend_ar && (r > MaxS || r < MinS);
      pend_rd    = w[27:26];
      pend_rs1   = w[25:24];
      pend_rs2   = w[23:22];
      pend_k     = cyc + 1;
      pend_end   = pend_k + (pend_wr ? 2 : 1);
      pend_valid = 1'b1;
   endtask

   // Per-cycle compare against the model, 1 time unit after each rising edge.
   initial begin
      bit busy, ret;
      forever begin
         @(posedge Clk);
         #1;
         cyc++;
         if (!Reset) begin
            chk("rst_ready", InstrReady, 1);
            chk("rst_regwrite", RegWrite, 0);
            chk("rst_done", Done, 0);
            chk("rst_illegal", Illegal, 0);
            chk("rst_zero", Zero, 0);
            chk("rst_ovf", Ovf, 0);
            chk("rst_readreg", {ReadReg1, ReadReg2, WriteReg}, 0);
            chk("rst_writedata", WriteData, 0);
         end else begin
            if (pend_valid && cyc == pend_k) begin
               m_rr1 = pend_rs1;
               m_rr2 = pend_rs2;
            end
            if (pend_valid && pend_wr && cyc == pend_k + 2) begin
               arch[pend_rd] = pend_res;
               m_zero = (pend_res == 32'h0);
               m_ovf  = pend_ar ? pend_ovf : 1'b0;
            end
            busy = pend_valid && cyc >= pend_k && cyc <= pend_end;
            ret  = pend_valid && cyc == pend_k + 2;
            chk("ready", InstrReady, !busy);
            chk("regwrite", RegWrite, ret && pend_wr);
            chk("done", Done, ret && !pend_ill);
            chk("illegal", Illegal, ret && pend_ill);
            chk("zero", Zero, m_zero);
            chk("ovf", Ovf, m_ovf);
            chk("readreg1", ReadReg1, m_rr1);
            chk("readreg2", ReadReg2, m_rr2);
            if (ret && pend_wr) begin
               chk("writereg", WriteReg, pend_rd);
               chk("writedata", WriteData, pend_res);
            end
         end
      end
   end

   task automatic issue(input logic [31:0] w);
      int t;
      t = 0;
      @(negedge Clk);
      while (pend_valid && cyc <= pend_end && t < 20) begin
         @(negedge Clk);
         t++;
      end
      if (t >= 20) begin
         n_cmp++;
         n_fail++;
         $display("FAIL issue_timeout at cycle %0d: got busy expected ready", cyc);
      end
      InstrValid  = 1'b1;
      Instruction = w;
      model_compute(w);
      @(posedge Clk);
      @(negedge Clk);
      InstrValid  = 1'b0;
      Instruction = $urandom;
   endtask

   // Returns once the last write has landed in the register file.
   task automatic wait_idle();
      int t;
      t = 0;
      @(negedge Clk);
      while (pend_valid && cyc <= pend_end + 1 && t < 20) begin
         @(negedge Clk);
         t++;
      end
      if (t >= 20) begin
         n_cmp++;
         n_fail++;
         $display("FAIL idle_timeout at cycle %0d: got busy expected idle", cyc);
      end
   endtask

   initial begin
      repeat (2) @(negedge Clk);
      Reset = 1'b1;

      // Reset mid-READ with InstrValid held: the LI R3 must never write.
      @(negedge Clk);
      InstrValid  = 1'b1;
      Instruction = enc(4'd8, 2'd3, 2'd2, 2'd1, 16'h1234);
      model_compute(Instruction);
      @(posedge Clk);
      #3;
      Reset      = 1'b0;
      pend_valid = 1'b0;
      m_zero     = 1'b0;
      m_ovf      = 1'b0;
      m_rr1      = '0;
      m_rr2      = '0;
      #1;
      chk("midread_regwrite", RegWrite, 0);
      chk("midread_readreg1", ReadReg1, 0);
      chk("midread_ready", InstrReady, 1);
      @(negedge Clk);
      InstrValid = 1'b0;
      @(posedge Clk);
      #3;
      Reset = 1'b1;
      chk("release_ready", InstrReady, 1);
      repeat (4) @(negedge Clk);
      chk("abandoned_r3", rf[3], 32'h0);

      issue(enc(4'd8, 2'd1, 2'd0, 2'd0, 16'h0005));
      issue(enc(4'd8, 2'd2, 2'd0, 2'd0, 16'hFFFF));
      wait_idle();
      chk("li_r1", rf[1], 32'h0000_0005);
      chk("li_r2", rf[2], 32'hFFFF_FFFF);
      chk("li_zero", Zero, 0);

      issue(enc(4'd6, 2'd0, 2'd2, 2'd1, 16'h0));
      wait_idle();
      chk("slt_r0", rf[0], 32'h1);
      issue(enc(4'd5, 2'd0, 2'd0, 2'd0, 16'h0));
      wait_idle();
      chk("xor_r0", rf[0], 32'h0);
      chk("xor_zero", Zero, 1);

      // Build R1 = 0x7FFFFFFF by doubling 2^14 up to 2^31 and subtracting 1.
      issue(enc(4'd8, 2'd1, 2'd0, 2'd0, 16'h4000));
      for (int i = 0; i < 17; i++) issue(enc(4'd1, 2'd1, 2'd1, 2'd1, 16'h0));
      issue(enc(4'd8, 2'd2, 2'd0, 2'd0, 16'h0001));
      issue(enc(4'd2, 2'd1, 2'd1, 2'd2, 16'h0));
      wait_idle();
      chk("build_r1", rf[1], 32'h7FFF_FFFF);
      chk("build_ovf", Ovf, 1);

      issue(enc(4'd1, 2'd3, 2'd1, 2'd2, 16'h0));
      wait_idle();
      chk("add_r3", rf[3], 32'h8000_0000);
      chk("add_ovf", Ovf, 1);
      issue(enc(4'd2, 2'd3, 2'd3, 2'd3, 16'h0));
      wait_idle();
      chk("sub_r3", rf[3], 32'h0);
      chk("sub_zero", Zero, 1);
      chk("sub_ovf", Ovf, 0);

      issue(enc(4'd3, 2'd0, 2'd1, 2'd2, 16'h0));
      issue(enc(4'd4, 2'd0, 2'd0, 2'd1, 16'h0));
      issue(enc(4'd7, 2'd0, 2'd0, 2'd0, 16'h0001));
      wait_idle();
      chk("addi_r0", rf[0], 32'h8000_0000);
      chk("addi_ovf", Ovf, 1);

      // Illegal then NOP: no writes, flags held.
      issue(enc(4'hF, 2'd3, 2'd1, 2'd2, 16'h0));
      issue(enc(4'h0, 2'd3, 2'd0, 2'd0, 16'h0));
      wait_idle();
      chk("illegal_r3", rf[3], 32'h0);
      chk("illegal_ovf_held", Ovf, 1);
      chk("illegal_zero_held", Zero, 0);

      issue(enc(4'd8, 2'd1, 2'd0, 2'd0, 16'h0006));
      issue(enc(4'd8, 2'd2, 2'd0, 2'd0, 16'hFFF9));
      issue(enc(4'd9, 2'd3, 2'd1, 2'd2, 16'h0));
      wait_idle();
`ifdef EXEC_SEQ_MUL_EN
      chk("mul_r3", rf[3], 32'hFFFF_FFD6);
`else
      chk("mul_illegal_r3", rf[3], 32'h0);
`endif
      chk("mul_ovf", Ovf, 0);

      repeat (2) @(negedge Clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
